// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised RAM.
// Holds the init FSM state enum, default sizes and the DEPTH helper.
package ram_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } ram_state_e;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 6;

   function automatic int depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Zero-initialisation sequencer: walks every address once after reset.
// Ports: clk, rst_n in; init_we_o, init_addr_o, busy_o out.
module ram_init_seq
   import ram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              init_we_o,
   output logic [ADDR_W-1:0] init_addr_o,
   output logic              busy_o
);

   localparam int            DEPTH = depth(ADDR_W);
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

   ram_state_e      state_q, state_d;
   logic [ADDR_W:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      init_we_o = 1'b0;
      unique case (state_q)
         INIT: begin
            init_we_o = 1'b1;
            cnt_d     = cnt_q + ONE;
            if (cnt_q == LAST) state_d = READY;
         end
         READY: begin
            state_d = READY;
         end
         default: state_d = INIT;
      endcase
   end

   assign init_addr_o = cnt_q[ADDR_W-1:0];
   assign busy_o      = (state_q == INIT);

endmodule

// File: rtl/ram_param.sv
// Single-port RAM, registered read with valid strobe, zeroed after reset.
// Ports: clk, rst_n, address, in, load, rd_en in; out, out_valid, busy out.
// Build option RAM_WRITE_FIRST_EN selects write-first same-cycle bypass.
module ram_param
   import ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] in,
   input  logic              load,
   input  logic              rd_en,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              busy
);

   localparam int DEPTH = depth(ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              init_we;
   logic [ADDR_W-1:0] init_addr;

   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic              rd_acc;
   logic [DATA_W-1:0] rdata;

   logic [DATA_W-1:0] out_q, out_d;
   logic              vld_q, vld_d;

   ram_init_seq #(.ADDR_W(ADDR_W)) u_init (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_we_o  (init_we),
      .init_addr_o(init_addr),
      .busy_o     (busy)
   );

   // The sequencer owns the write port until init completes.
   always_comb begin
      we     = load;
      wa     = address;
      wd     = in;
      rd_acc = rd_en & ~busy;
      if (busy) begin
         we = init_we;
         wa = init_addr;
         wd = '0;
      end
   end

`ifdef RAM_WRITE_FIRST_EN
   always_comb begin
      rdata = mem[address];
      if (load) rdata = in;
   end
`else
   always_comb begin
      rdata = mem[address];
   end
`endif

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   always_comb begin
      out_d = out_q;
      vld_d = rd_acc;
      if (rd_acc) out_d = rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
         vld_q <= 1'b0;
      end else begin
         out_q <= out_d;
         vld_q <= vld_d;
      end
   end

   assign out       = out_q;
   assign out_valid = vld_q;

endmodule

// File: tb/tb_ram_param.sv
// Directed scoreboard bench for ram_param (default and 8x8 instances).
// Expected read data is queued at request time, popped on out_valid.
`timescale 1ns/1ps
module tb_ram_param;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [5:0]  addr_a = '0;
   logic [15:0] in_a = '0;
   logic        load_a = 1'b0;
   logic        rd_a = 1'b0;
   logic [15:0] out_a;
   logic        vld_a;
   logic        busy_a;

   logic [2:0]  addr_b = '0;
   logic [7:0]  in_b = '0;
   logic        load_b = 1'b0;
   logic        rd_b = 1'b0;
   logic [7:0]  out_b;
   logic        vld_b;
   logic        busy_b;

   int passed = 0;
   int total  = 0;
   logic [15:0] sbq[$];

   always #5 clk = ~clk;

   ram_param dut_a (
      .clk(clk), .rst_n(rst_n), .address(addr_a), .in(in_a),
      .load(load_a), .rd_en(rd_a), .out(out_a),
      .out_valid(vld_a), .busy(busy_a)
   );

   ram_param #(.DATA_W(8), .ADDR_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .address(addr_b), .in(in_b),
      .load(load_b), .rd_en(rd_b), .out(out_b),
      .out_valid(vld_b), .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_chk(input string tag, input logic [15:0] obs);
      logic [15:0] e;
      if (sbq.size() == 0) begin
         chk({tag, "_sbq_empty"}, 16'd1, 16'd0);
      end else begin
         e = sbq.pop_front();
         chk(tag, obs, e);
      end
   endtask

   task automatic wr_a(input logic [5:0] a, input logic [15:0] d);
      addr_a = a; in_a = d; load_a = 1'b1;
      tick();
      load_a = 1'b0;
   endtask

   task automatic rd_chk_a(input string tag, input logic [5:0] a,
                           input logic [15:0] e);
      addr_a = a; rd_a = 1'b1;
      sbq.push_back(e);
      tick();
      rd_a = 1'b0;
      chk({tag, "_vld"}, {15'd0, vld_a}, 16'd1);
      pop_chk(tag, out_a);
   endtask

   task automatic wait_init(input string tag, input int exp_n,
                            input bit use_b);
      int n;
      n = 0;
      while ((use_b ? busy_b : busy_a) && n < 200) begin
         tick();
         n++;
      end
      chk(tag, 16'(n), 16'(exp_n));
   endtask

   initial begin
      int bad;
      logic [15:0] old9;
      #2;
      chk("rst_out", out_a, 16'h0000);
      chk("rst_vld", {15'd0, vld_a}, 16'd0);
      chk("rst_busy", {15'd0, busy_a}, 16'd1);

      // requests during init must be ignored
      addr_a = 6'd3; in_a = 16'hAAAA; load_a = 1'b1; rd_a = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 0;
      begin
         int n;
         n = 0;
         while (busy_a && n < 200) begin
            tick();
            n++;
            if (vld_a !== 1'b0 || out_a !== 16'h0) bad++;
            if (busy_a) begin
               addr_a = 6'd3;
            end
         end
         load_a = 1'b0; rd_a = 1'b0;
         chk("init_cycles", 16'(n), 16'd64);
      end
      chk("busy_quiet", 16'(bad), 16'd0);
      chk("busy_b_done", {15'd0, busy_b}, 16'd0);

      rd_chk_a("zero0", 6'd0, 16'h0000);
      rd_chk_a("zero31", 6'd31, 16'h0000);
      rd_chk_a("zero63", 6'd63, 16'h0000);
      rd_chk_a("busy_nowr3", 6'd3, 16'h0000);

      wr_a(6'd5, 16'hBEEF);
      rd_chk_a("rd5", 6'd5, 16'hBEEF);
      tick();
      chk("hold_vld", {15'd0, vld_a}, 16'd0);
      chk("hold_out", out_a, 16'hBEEF);

      // same-cycle write and read
      addr_a = 6'd9; in_a = 16'h1234; load_a = 1'b1; rd_a = 1'b1;
`ifdef RAM_WRITE_FIRST_EN
      old9 = 16'h1234;
`else
      old9 = 16'h0000;
`endif
      sbq.push_back(old9);
      tick();
      load_a = 1'b0; rd_a = 1'b0;
      chk("rw9_vld", {15'd0, vld_a}, 16'd1);
      pop_chk("rw9", out_a);
      rd_chk_a("rd9", 6'd9, 16'h1234);

      // reset mid-read and mid-init
      wr_a(6'd7, 16'hFFFF);
      rd_chk_a("rd7", 6'd7, 16'hFFFF);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", out_a, 16'h0000);
      chk("arst_vld", {15'd0, vld_a}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) tick();
      chk("mid_busy", {15'd0, busy_a}, 16'd1);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_init("reinit_cycles", 64, 1'b0);
      rd_chk_a("rd7_zero", 6'd7, 16'h0000);
      rd_chk_a("rd5_zero", 6'd5, 16'h0000);

      // small instance: 8-cycle init and streaming
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_init("b_init_cycles", 8, 1'b1);
      for (int i = 0; i < 8; i++) begin
         addr_b = 3'(i); in_b = 8'(8'h3C ^ (i * 37)); load_b = 1'b1;
         tick();
      end
      load_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         addr_b = 3'(i); rd_b = 1'b1;
         sbq.push_back({8'h00, 8'(8'h3C ^ (i * 37))});
         tick();
         chk("b_stream_vld", {15'd0, vld_b}, 16'd1);
         pop_chk("b_stream", {8'h00, out_b});
      end
      rd_b = 1'b0;
      tick();
      chk("b_vld_drop", {15'd0, vld_b}, 16'd0);
      chk("sbq_drained", 16'(sbq.size()), 16'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram_param.md
Name: ram_param

Overview:
Parametrised successor to the fixed-size Nand2Tetris-style RAM blocks.
- Clocked, width/depth-generic single-port RAM with registered read, a read-valid strobe, and a hardware zero-initialisation sequencer after reset.
- Serves as the common memory primitive for the RAM hierarchy and the CPU data memory.
- Replaces the level-triggered, uninitialised fixed-depth variants.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 6, address width; DEPTH = 2**ADDR_W words (default 64)

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
address  input  ADDR_W  word address for write and read
in  input  DATA_W  write data
load  input  1  write enable, sampled at posedge clk
rd_en  input  1  read request, sampled at posedge clk
out  output  DATA_W  registered read data
out_valid  output  1  one-cycle strobe: out carries data for the request accepted on the previous edge
busy  output  1  high while the init sequencer runs; requests are ignored

Behaviour:
- Reset (rst_n low, asynchronous): out=0, out_valid=0, busy=1, FSM=INIT, init counter=0. Memory contents are not touched by reset itself.
- FSM state INIT:
  - Each cycle writes 0 to mem[init_cnt], then increments init_cnt.
  - After writing DEPTH-1, moves to READY and busy drops the following cycle.
  - Init takes exactly DEPTH cycles after reset release: busy is high for DEPTH rising edges, then low.
- FSM state READY: steady state; no exit except reset.
- While busy=1:
  - load and rd_en are ignored.
  - out_valid stays 0.
  - out holds 0.
- Write (READY): load=1 at posedge writes in to mem[address]. No output effect unless a read is also requested.
- Read (READY): rd_en=1 at posedge
  - out <= mem[address] and out_valid=1 for exactly one cycle; latency is 1 cycle.
  - With rd_en=0, out holds its last value and out_valid=0.
- Back-to-back reads: one per cycle; out_valid stays high on consecutive cycles.
- Same-cycle load and rd_en, same address: read-first by default, so out gets the pre-write contents. See the optional feature.
- Same-cycle load and rd_en, different addresses: both complete independently.
- Address range: full range is valid; there is no out-of-range case since DEPTH = 2**ADDR_W.
- Reset mid-init or mid-read:
  - Asynchronously clears out and out_valid.
  - Restarts INIT from address 0.
  - A partially completed init is redone in full.
- Width rules: the init counter is ADDR_W+1 bits; the terminal compare is against DEPTH-1.

Optional Feature:
RAM_WRITE_FIRST_EN
- Defined: a same-cycle load and rd_en to the same address returns in (the new data) on out, i.e. write-first bypass.
- Undefined: read-first; out returns the old contents.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package ram_pkg holds:
  - the state enum (INIT, READY);
  - default DATA_W/ADDR_W constants;
  - a DEPTH helper function.
- One sub-module is natural: ram_init_seq.
  - Contains the INIT/READY FSM and the counter.
  - Outputs init_we, init_addr and busy.
  - The top muxes the write port between ram_init_seq and the user interface.

Test Plan:
- Release rst_n -> busy=1 for exactly 64 cycles, then 0; a read of addresses 0, 31 and 63 returns 0x0000 with out_valid after 1 cycle.
- Write 0xBEEF to address 5, then rd_en at address 5 on the next cycle -> out=0xBEEF and out_valid=1 one cycle after the read edge; out holds 0xBEEF once rd_en drops.
- Write 0x1234 to address 9 with load and rd_en in the same cycle:
  - macro undefined -> out=0x0000;
  - RAM_WRITE_FIRST_EN defined -> out=0x1234;
  - a follow-up read returns 0x1234 in both builds.
- Assert load (address 3, 0xAAAA) and rd_en during busy -> no write and out_valid=0; after init, a read of address 3 returns 0x0000.
- Write 0xFFFF to address 7, then pulse rst_n low mid-init at cycle 20 -> out=0 and out_valid=0 immediately; busy is held for a full 64 cycles after release; address 7 reads 0x0000.
- Instantiate with DATA_W=8, ADDR_W=3 -> 8-cycle init; streaming writes then reads of 8 distinct values return each value in order with out_valid high on consecutive cycles.
